// File: rtl/cpu_memaccess.sv
// cpu_memaccess: memory-access stage between the commit register and writeback.
// Issues load/store requests over a valid/ready channel, waits for the load
// response, aligns and extends load data, and presents a registered writeback
// bundle. Non-memory ops pass through with one cycle of latency.
module cpu_memaccess #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  // commit side
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_reg_write,
  input  logic [REG_ADDR_W-1:0] in_reg_dest,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic [1:0]            in_size,
  input  logic                  in_unsigned,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_store_data,
  // data-memory request channel
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [XLEN-1:0]       mem_req_addr,
  output logic [XLEN-1:0]       mem_req_wdata,
  output logic [3:0]            mem_req_wstrb,
  // data-memory response channel
  input  logic                  mem_resp_valid,
  input  logic [XLEN-1:0]       mem_resp_rdata,
  // writeback bundle
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_reg_dest,
  output logic [XLEN-1:0]       wb_data,
  output logic                  wb_misaligned,
  // hazard unit
  output logic [REG_ADDR_W-1:0] busy_rd,
  output logic                  busy_load
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                  state_q;

  // Op fields latched at acceptance, needed once the response returns.
  logic                    reg_write_q;
  logic [REG_ADDR_W-1:0]   reg_dest_q;
  logic [1:0]              size_q;
  logic                    unsigned_q;
  logic [1:0]              offset_q;

  // Registered outputs.
  logic                    mem_req_valid_q;
  logic                    mem_req_write_q;
  logic [XLEN-1:0]         mem_req_addr_q;
  logic [XLEN-1:0]         mem_req_wdata_q;
  logic [3:0]              mem_req_wstrb_q;
  logic                    wb_valid_q;
  logic                    wb_reg_write_q;
  logic [REG_ADDR_W-1:0]   wb_reg_dest_q;
  logic [XLEN-1:0]         wb_data_q;
  logic                    wb_misaligned_q;
  logic [REG_ADDR_W-1:0]   busy_rd_q;
  logic                    busy_load_q;

  // Decode of the incoming op.
  logic                    is_mem_d;
  logic                    misaligned_d;
  logic [XLEN-1:0]         st_wdata_d;
  logic [3:0]              st_wstrb_d;

  // Aligned/extended load result.
  logic [7:0]              ld_byte_d;
  logic [15:0]             ld_half_d;
  logic [XLEN-1:0]         ld_data_d;

  assign in_ready = (state_q == IDLE);

  // Classify the incoming op and build lane-replicated store data/strobes.
  // NOTE: every variable gets a default at the top so no path leaves it unassigned and infers a latch.
  always_comb begin
    is_mem_d     = in_mem_read | in_mem_write;
    misaligned_d = 1'b0;
    st_wdata_d   = in_store_data;
    st_wstrb_d   = 4'b1111;
    case (in_size)
      2'b00: begin
        st_wdata_d = {4{in_store_data[7:0]}};
        st_wstrb_d = 4'b0001 << in_alu_result[1:0];
      end
      2'b01: begin
        misaligned_d = in_alu_result[0];
        st_wdata_d   = {2{in_store_data[15:0]}};
        st_wstrb_d   = 4'b0011 << {in_alu_result[1], 1'b0};
      end
      default: begin
        // Size 11 is handled exactly like a word access.
        misaligned_d = (in_alu_result[1:0] != 2'b00);
      end
    endcase
  end

  // Select the addressed lane of the response word and extend it.
  always_comb begin
    case (offset_q)
      2'd0:    ld_byte_d = mem_resp_rdata[7:0];
      2'd1:    ld_byte_d = mem_resp_rdata[15:8];
      2'd2:    ld_byte_d = mem_resp_rdata[23:16];
      default: ld_byte_d = mem_resp_rdata[31:24];
    endcase
    ld_half_d = offset_q[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];
    case (size_q)
      2'b00:   ld_data_d = unsigned_q ? {{(XLEN-8){1'b0}}, ld_byte_d}
                                      : {{(XLEN-8){ld_byte_d[7]}}, ld_byte_d};
      2'b01:   ld_data_d = unsigned_q ? {{(XLEN-16){1'b0}}, ld_half_d}
                                      : {{(XLEN-16){ld_half_d[15]}}, ld_half_d};
      default: ld_data_d = mem_resp_rdata;
    endcase
  end

  // Control FSM with all outputs registered; wb_valid defaults low so it pulses.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      reg_write_q     <= 1'b0;
      reg_dest_q      <= '0;
      size_q          <= 2'b00;
      unsigned_q      <= 1'b0;
      offset_q        <= 2'b00;
      mem_req_valid_q <= 1'b0;
      mem_req_write_q <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
      mem_req_wstrb_q <= 4'b0000;
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_reg_dest_q   <= '0;
      wb_data_q       <= '0;
      wb_misaligned_q <= 1'b0;
      busy_rd_q       <= '0;
      busy_load_q     <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            reg_write_q <= in_reg_write;
            reg_dest_q  <= in_reg_dest;
            size_q      <= in_size;
            unsigned_q  <= in_unsigned;
            offset_q    <= in_alu_result[1:0];
            if (!is_mem_d) begin
              wb_valid_q      <= 1'b1;
              wb_reg_write_q  <= in_reg_write;
              wb_reg_dest_q   <= in_reg_dest;
              wb_data_q       <= in_alu_result;
              wb_misaligned_q <= 1'b0;
            end else if (misaligned_d) begin
              // Faulting access: report it and never touch memory.
              wb_valid_q      <= 1'b1;
              wb_reg_write_q  <= 1'b0;
              wb_reg_dest_q   <= in_reg_dest;
              wb_data_q       <= in_alu_result;
              wb_misaligned_q <= 1'b1;
            end else begin
              state_q         <= REQ;
              mem_req_valid_q <= 1'b1;
              mem_req_write_q <= in_mem_write;
              mem_req_addr_q  <= {in_alu_result[XLEN-1:2], 2'b00};
              mem_req_wdata_q <= in_mem_write ? st_wdata_d : '0;
              mem_req_wstrb_q <= in_mem_write ? st_wstrb_d : 4'b0000;
              busy_load_q     <= in_mem_read;
              if (in_mem_read) begin
                busy_rd_q <= in_reg_dest;
              end
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            if (mem_req_write_q) begin
              // Stores complete at the handshake; no response follows.
              state_q         <= IDLE;
              wb_valid_q      <= 1'b1;
              wb_reg_write_q  <= 1'b0;
              wb_reg_dest_q   <= reg_dest_q;
              wb_misaligned_q <= 1'b0;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            state_q         <= IDLE;
            busy_load_q     <= 1'b0;
            wb_valid_q      <= 1'b1;
            wb_reg_write_q  <= reg_write_q;
            wb_reg_dest_q   <= reg_dest_q;
            wb_data_q       <= ld_data_d;
            wb_misaligned_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_write = mem_req_write_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_wdata = mem_req_wdata_q;
  assign mem_req_wstrb = mem_req_wstrb_q;
  assign wb_valid      = wb_valid_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_reg_dest   = wb_reg_dest_q;
  assign wb_data       = wb_data_q;
  assign wb_misaligned = wb_misaligned_q;
  assign busy_rd       = busy_rd_q;
  assign busy_load     = busy_load_q;

endmodule

// File: doc/cpu_memaccess.md
Name: cpu_memaccess

Overview:
- Memory-access stage directly downstream of the commit pipeline register and upstream of writeback.
- Turns committed load/store micro-ops into data-memory requests over a valid/ready request channel and a valid-only response channel.
- Aligns and sign/zero-extends load data, then presents a registered writeback bundle.
- Passes non-memory ops through with 1-cycle latency; stalls upstream while a memory access is outstanding.

Parameters:
- XLEN, 32, datapath/address width (RTL supports only 32).
- REG_ADDR_W, 5, destination register index width.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  committed op present
- in_ready  out  1  stage can accept op this cycle
- in_reg_write  in  1  op writes register file
- in_reg_dest  in  REG_ADDR_W  destination register
- in_mem_read  in  1  load
- in_mem_write  in  1  store (never both read and write)
- in_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- in_unsigned  in  1  zero-extend load (else sign-extend)
- in_alu_result  in  XLEN  ALU result / effective address
- in_store_data  in  XLEN  store source value
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_write  out  1  1 store, 0 load
- mem_req_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- mem_req_wdata  out  XLEN  lane-replicated store data
- mem_req_wstrb  out  4  byte enables (stores); 0 for loads
- mem_resp_valid  in  1  load data valid (one pulse per load)
- mem_resp_rdata  in  XLEN  full word read
- wb_valid  out  1  writeback bundle valid (1-cycle pulse per op)
- wb_reg_write  out  1  register write enable
- wb_reg_dest  out  REG_ADDR_W  destination
- wb_data  out  XLEN  ALU result or extended load data
- wb_misaligned  out  1  access fault flag
- busy_rd  out  REG_ADDR_W  dest of in-flight load (hazard unit)
- busy_load  out  1  a load is in flight (REQ or WAIT)

Behaviour:
- FSM states IDLE, REQ, WAIT.
- in_ready = (state==IDLE). An op is accepted when in_valid && in_ready. All op fields are latched on acceptance.
- Reset: state IDLE. All outputs 0, including mem_req_valid, wb_valid, wb_* fields and busy_*.
- Non-memory op accepted at cycle T:
  - wb_valid=1 at T+1.
  - wb_data=in_alu_result; wb_reg_write/reg_dest copied.
  - State stays IDLE, so back-to-back ALU ops flow at 1/cycle.
- Misalignment check, done at acceptance:
  - half with addr[0]=1, or word/11 with addr[1:0]!=0.
  - Result: no request issued; at T+1 wb_valid=1, wb_misaligned=1, wb_reg_write=0; stay IDLE.
- Aligned memory op accepted at T:
  - Enter REQ.
  - mem_req_valid=1 from T+1, held stable with all req fields constant until mem_req_ready.
- Store, handshake at cycle H:
  - Enter IDLE at H+1 with wb_valid=1, wb_reg_write=0. No response is expected.
- Load, handshake at cycle H:
  - Enter WAIT.
  - On mem_resp_valid at cycle R: wb_valid=1 at R+1, then return to IDLE.
  - wb_data = lane selected by addr[1:0] (byte) or addr[1] (half), extended per in_unsigned.
- Store data:
  - byte → {4{d[7:0]}}, wstrb=0001<<addr[1:0].
  - half → {2{d[15:0]}}, wstrb=0011<<{addr[1],0}.
  - word → d, wstrb=1111.
- wb_valid is a single-cycle pulse. All other wb_* fields hold their last values when wb_valid=0.
- mem_resp_valid outside WAIT is ignored.
- busy_load=1 in REQ and WAIT; busy_rd = latched dest.
- Reset mid-operation (REQ or WAIT): return to IDLE next cycle, drop mem_req_valid, suppress wb_valid. A response arriving after reset is ignored.

Test Plan:
- Reset held 2 cycles, then released → all outputs 0, in_ready=1; mem_resp_valid pulse in IDLE gives no wb_valid.
- ALU ops r3=0x11, r4=0x22 on consecutive cycles → wb_valid on both next cycles, wb_data 0x11 then 0x22, in_ready stays 1, no mem_req_valid.
- Load byte signed, addr 0x1003, rdata 0x80FF_0000, ready after 2 cycles, resp 3 cycles later:
  - mem_req_addr=0x1000, wstrb=0, req held stable while ready=0.
  - wb_data=0xFFFF_FF80 one cycle after resp.
  - in_ready=0 throughout the access.
- Store half, addr 0x2002, data 0x1234_ABCD → wdata=0xABCD_ABCD, wstrb=1100, wb_valid with wb_reg_write=0 one cycle after handshake.
- Load word at 0x3001 → no mem_req_valid, next cycle wb_valid=1, wb_misaligned=1, wb_reg_write=0.
- Load issued, reset asserted in WAIT, resp arrives after reset → IDLE, wb_valid never asserted, busy_load=0.
